// File: rtl/square_wave_sequencer.sv
// Note-table sequencer for a square-wave tone generator: steps through
// (frequency, duration) entries and gates the generator per note.
module square_wave_sequencer #(
  parameter  int counter_width = 8,
  parameter  int dur_width     = 12,
  parameter  int num_notes     = 16,
  parameter  int tick_div      = 4,
  parameter  int gap_ticks     = 1,
  localparam int IW            = (num_notes > 1) ? $clog2(num_notes) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_addr,
  input  logic [counter_width-1:0] wr_freq,
  input  logic [dur_width-1:0]     wr_dur,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic [counter_width-1:0] frequency_control,
  output logic                     tone_enable,
  output logic [IW-1:0]            note_index,
  output logic                     busy,
  output logic                     done
);
  localparam int PW = (tick_div > 1) ? $clog2(tick_div) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_DONE} state_t;

  logic [counter_width-1:0] r_tbl_freq [num_notes];
  logic [dur_width-1:0]     r_tbl_dur  [num_notes];

  state_t                   r_state, w_state;
  logic [IW-1:0]            r_idx, w_idx;
  logic [PW-1:0]            r_pre, w_pre;
  logic [dur_width-1:0]     r_dur, w_dur;
  logic [counter_width-1:0] r_freq, w_freq;
  logic                     r_ten, w_ten;
  logic                     r_loop, w_loop;
  logic                     r_busy, w_busy;
  logic                     r_done, w_done;

  logic [counter_width-1:0] w_rd_freq;
  logic [dur_width-1:0]     w_rd_dur;
  logic                     w_wrap, w_last;
  state_t                   w_adv_state;
  logic [IW-1:0]            w_adv_idx;

  // Table is deliberately outside the reset domain so it survives reset.
  always_ff @(posedge clk) begin
    if (wr_en && !r_busy) begin
      r_tbl_freq[wr_addr] <= wr_freq;
      r_tbl_dur[wr_addr]  <= wr_dur;
    end
  end

  assign w_rd_freq = r_tbl_freq[r_idx];
  assign w_rd_dur  = r_tbl_dur[r_idx];
  assign w_wrap    = (r_pre == PW'(tick_div - 1));
  // PLAY and GAP share the prescaler and the tick down-counter.
  assign w_last    = w_wrap && (r_dur == dur_width'(1));

  always_comb begin
    w_adv_state = S_FETCH;
    w_adv_idx   = r_idx + IW'(1);
    if (r_idx == IW'(num_notes - 1)) begin
      w_adv_idx = '0;
      if (!r_loop) begin
        w_adv_state = S_DONE;
        w_adv_idx   = r_idx;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_pre   = r_pre;
    w_dur   = r_dur;
    w_freq  = r_freq;
    w_ten   = r_ten;
    w_loop  = r_loop;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state = S_FETCH;
          w_idx   = '0;
          w_loop  = loop;
        end
      end
      S_FETCH: begin
        if (w_rd_dur != '0) begin
          w_state = S_PLAY;
          w_freq  = w_rd_freq;
          w_ten   = (w_rd_freq != '0);
          w_dur   = w_rd_dur;
          w_pre   = '0;
        end else if (r_loop && r_idx != '0) begin
          w_idx = '0;
        end else begin
          w_state = S_DONE;
        end
      end
      S_PLAY, S_GAP: begin
        w_pre = w_wrap ? '0 : r_pre + PW'(1);
        if (w_wrap) w_dur = r_dur - dur_width'(1);
        if (w_last) begin
          if (r_state == S_PLAY && gap_ticks > 0) begin
            w_state = S_GAP;
            w_dur   = dur_width'(gap_ticks);
            w_pre   = '0;
          end else begin
            w_state = w_adv_state;
            w_idx   = w_adv_idx;
          end
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    if (stop && r_state != S_IDLE) w_state = S_IDLE;
    if (w_state != S_PLAY) w_ten = 1'b0;
    w_busy = (w_state == S_FETCH) || (w_state == S_PLAY) || (w_state == S_GAP);
    w_done = (w_state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pre   <= '0;
      r_dur   <= '0;
      r_freq  <= '0;
      r_ten   <= 1'b0;
      r_loop  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_pre   <= w_pre;
      r_dur   <= w_dur;
      r_freq  <= w_freq;
      r_ten   <= w_ten;
      r_loop  <= w_loop;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign frequency_control = r_freq;
  assign tone_enable       = r_ten;
  assign note_index        = r_idx;
  assign busy              = r_busy;
  assign done              = r_done;
endmodule

// File: tb/tb_square_wave_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle output traces,
// a negedge monitor pops and compares them against the DUT.
module tb_square_wave_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_freq = '0;
  logic [11:0] wr_dur = '0;
  logic       start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [7:0] frequency_control;
  logic       tone_enable;
  logic [3:0] note_index;
  logic       busy, done;

  square_wave_sequencer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_freq(wr_freq), .wr_dur(wr_dur), .start(start), .stop(stop),
    .loop(loop), .frequency_control(frequency_control),
    .tone_enable(tone_enable), .note_index(note_index), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] f;
    logic       en;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0, n_trace = 0;
  exp_t m_e, m_a;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_e = exp_q.pop_front();
      m_a = '{frequency_control, tone_enable, note_index, busy, done};
      n_chk++;
      if (m_a === m_e) n_pass++;
      else $display("FAIL trace[%0d] got f=%0d en=%0b idx=%0d busy=%0b done=%0b want f=%0d en=%0b idx=%0d busy=%0b done=%0b",
                    n_trace, m_a.f, m_a.en, m_a.idx, m_a.busy, m_a.done,
                    m_e.f, m_e.en, m_e.idx, m_e.busy, m_e.done);
      n_trace++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int n, input int f, input bit en, input int idx,
                    input bit b, input bit d);
    exp_t e;
    e = '{8'(f), en, 4'(idx), b, d};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic wr(input int a, input int f, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_freq = 8'(f); wr_dur = 12'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_%s got %0d entries left want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // 3-entry song: (40,3) then rest (0,2) then end marker; tick_div=4, gap 1 tick.
  task automatic song_trace(input int f0, input int idx0);
    ex(1, f0, 0, idx0, 0, 0);
    ex(1, f0, 0, 0, 1, 0);
    ex(12, 40, 1, 0, 1, 0);
    ex(4, 40, 0, 0, 1, 0);
    ex(1, 40, 0, 1, 1, 0);
    ex(8, 0, 0, 1, 1, 0);
    ex(4, 0, 0, 1, 1, 0);
    ex(1, 0, 0, 2, 1, 0);
    ex(1, 0, 0, 2, 0, 1);
    ex(2, 0, 0, 2, 0, 0);
  endtask

  // mode 1: write entry 0 while busy; mode 2: re-pulse start while busy.
  task automatic play_song(input int f0, input int idx0, input int mode, input string name);
    song_trace(f0, idx0);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (mode == 1) begin
      repeat (3) tick();
      wr(0, 99, 3);
    end else if (mode == 2) begin
      repeat (5) tick();
      start = 1'b1; loop = 1'b1;
      tick();
      start = 1'b0; loop = 1'b0;
    end
    drain(name);
  endtask

  task automatic check_zero(input string name);
    n_chk++;
    if (frequency_control === 8'd0 && tone_enable === 1'b0 && note_index === 4'd0 &&
        busy === 1'b0 && done === 1'b0) n_pass++;
    else $display("FAIL %s got f=%0d en=%0b idx=%0d busy=%0b done=%0b want all zero",
                  name, frequency_control, tone_enable, note_index, busy, done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_zero("reset_state");

    wr(0, 40, 3); wr(1, 0, 2); wr(2, 7, 0);
    play_song(0, 0, 1, "song_wr_busy");
    play_song(0, 2, 0, "song_replay");

    // Loop mode: 16 one-tick notes, two full passes then stop mid-PLAY.
    for (int i = 0; i < 16; i++) wr(i, i + 1, 1);
    ex(1, 0, 0, 2, 0, 0);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++) begin
        ex(1, (p == 0 && i == 0) ? 0 : ((i == 0) ? 16 : i), 0, i, 1, 0);
        ex(4, i + 1, 1, i, 1, 0);
        ex(4, i + 1, 0, i, 1, 0);
      end
    ex(1, 16, 0, 0, 1, 0);
    ex(2, 1, 1, 0, 1, 0);
    ex(2, 1, 0, 0, 0, 0);
    start = 1'b1; loop = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0;
    repeat (290) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drain("loop_stop");

    // End marker at index 0 in loop mode: straight to DONE.
    wr(0, 5, 0);
    ex(1, 1, 0, 0, 0, 0);
    ex(1, 1, 0, 0, 1, 0);
    ex(1, 1, 0, 0, 0, 1);
    ex(2, 1, 0, 0, 0, 0);
    start = 1'b1; loop = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0;
    drain("marker_idx0");

    // start and stop together in IDLE: stop wins.
    ex(3, 1, 0, 0, 0, 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    drain("start_stop_idle");

    wr(0, 40, 3); wr(1, 0, 2); wr(2, 7, 0);
    play_song(1, 0, 2, "start_while_busy");

    // Async reset mid-PLAY, then replay the untouched table.
    ex(1, 0, 0, 2, 0, 0);
    ex(1, 0, 0, 0, 1, 0);
    ex(5, 40, 1, 0, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    #1 reset = 1'b0;
    drain("pre_reset");
    tick();
    play_song(0, 0, 0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
